pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Tracks in-flight destination registers in a DEPTH-slot scoreboard (slot 0 = EX, slot DEPTH-1 = WB).
- Generates the ID-stage stall, pipeline flush strobes on control-flow redirect, and registered forwarding selects for the EX operand muxes.
- Keeps a saturating stall counter for performance analysis.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
//
// A DEPTH-slot scoreboard follows the instructions issued past ID.
// Slot 0 holds the instruction in EX and slot DEPTH-1 holds the one in WB.
// Each cycle the controller compares the ID sources against the scoreboard and
// produces:
//   - an ID-stage stall,
//   - flush strobes on a control-flow redirect,
//   - registered forwarding selects for the EX operand muxes,
//   - a saturating count of stall cycles.
//
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   en                       advance enable; 0 freezes all state
//   id_valid                 ID holds a valid instruction
//   id_rs1, id_rs2           source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2 the ID instruction reads that source
//   id_rd                    destination register of the ID instruction
//   id_reg_write             the ID instruction writes id_rd
//   id_is_load               the ID instruction is a load
//   redirect                 taken branch or jump resolved this cycle
//   stall                    hold PC and IF/ID, insert a bubble into ID/EX
//   flush_if_id, flush_id_ex squash strobes for the pipeline registers
//   fwd_sel_rs1, fwd_sel_rs2 EX operand source:
//                              0     = register file
//                              k     = result of slot k
//                              DEPTH = WB data latched one cycle
//   stall_cnt                saturating count of stall cycles
module pipe_hazard_ctrl #(
    parameter int unsigned  REG_ADDR_W = 5,
    parameter int unsigned  DEPTH      = 3,
    parameter bit           FWD_EN     = 1'b1,
    parameter int unsigned  LOAD_LAT   = 1,
    parameter int unsigned  KILL_SLOTS = 1,
    parameter int unsigned  CNT_W      = 32,
    localparam int unsigned FS_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [FS_W-1:0]       fwd_sel_rs1,
    output logic [FS_W-1:0]       fwd_sel_rs2,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Scoreboard slots: {valid, rd, reg_write, is_load}
    logic                  slot_valid_q [DEPTH];
    logic [REG_ADDR_W-1:0] slot_rd_q    [DEPTH];
    logic                  slot_we_q    [DEPTH];
    logic                  slot_ld_q    [DEPTH];

    logic [FS_W-1:0]       fwd_sel_rs1_q, fwd_sel_rs1_d;
    logic [FS_W-1:0]       fwd_sel_rs2_q, fwd_sel_rs2_d;
    logic [CNT_W-1:0]      stall_cnt_q;

    logic                  hit_rs1, hit_rs2;
    int                    idx_rs1, idx_rs2;
    logic                  haz_rs1, haz_rs2;
    logic                  id_enter;

    // Youngest matching slot per source. Scanning from oldest to youngest lets
    // the lowest index overwrite any older match.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        idx_rs1 = 0;
        idx_rs2 = 0;
        for (int j = int'(DEPTH) - 1; j >= 0; j--) begin
            if (slot_valid_q[j] && slot_we_q[j]) begin
                if (id_uses_rs1 && (id_rs1 != '0) && (slot_rd_q[j] == id_rs1)) begin
                    hit_rs1 = 1'b1;
                    idx_rs1 = j;
                end
                if (id_uses_rs2 && (id_rs2 != '0) && (slot_rd_q[j] == id_rs2)) begin
                    hit_rs2 = 1'b1;
                    idx_rs2 = j;
                end
            end
        end
    end

    // Without forwarding any in-flight producer blocks, including WB, because
    // the register file has no write-through. With forwarding only a load
    // whose data is not yet available blocks.
    always_comb begin
        haz_rs1 = 1'b0;
        haz_rs2 = 1'b0;
        if (hit_rs1) begin
            haz_rs1 = !FWD_EN || (slot_ld_q[idx_rs1] && (idx_rs1 < int'(LOAD_LAT)));
        end
        if (hit_rs2) begin
            haz_rs2 = !FWD_EN || (slot_ld_q[idx_rs2] && (idx_rs2 < int'(LOAD_LAT)));
        end
    end

    // A redirect makes the ID instruction wrong-path, so it never stalls.
    assign stall       = id_valid && (haz_rs1 || haz_rs2) && !redirect;
    assign flush_if_id = redirect;
    assign flush_id_ex = redirect;
    assign id_enter    = id_valid && !stall && !redirect;

    always_comb begin
        fwd_sel_rs1_d = '0;
        fwd_sel_rs2_d = '0;
        if (FWD_EN && id_enter) begin
            if (hit_rs1) fwd_sel_rs1_d = FS_W'(idx_rs1 + 1);
            if (hit_rs2) fwd_sel_rs2_d = FS_W'(idx_rs2 + 1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_valid_q[k] <= 1'b0;
                slot_rd_q[k]    <= '0;
                slot_we_q[k]    <= 1'b0;
                slot_ld_q[k]    <= 1'b0;
            end
            fwd_sel_rs1_q <= '0;
            fwd_sel_rs2_q <= '0;
            stall_cnt_q   <= '0;
        end else if (en) begin
            // Shift toward WB. The youngest KILL_SLOTS entries are wrong-path
            // on a redirect and are written invalid.
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                slot_valid_q[k] <= slot_valid_q[k-1] && !(redirect && (k <= int'(KILL_SLOTS)));
                slot_rd_q[k]    <= slot_rd_q[k-1];
                slot_we_q[k]    <= slot_we_q[k-1];
                slot_ld_q[k]    <= slot_ld_q[k-1];
            end
            slot_valid_q[0] <= id_enter;
            slot_rd_q[0]    <= id_rd;
            slot_we_q[0]    <= id_reg_write;
            slot_ld_q[0]    <= id_is_load;
            fwd_sel_rs1_q   <= fwd_sel_rs1_d;
            fwd_sel_rs2_q   <= fwd_sel_rs2_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_sel_rs1 = fwd_sel_rs1_q;
    assign fwd_sel_rs2 = fwd_sel_rs2_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives one stimulus stream into two controllers:
//   - u_dut_fwd: forwarding enabled
//   - u_dut_nof: forwarding disabled
// Both are checked against an age-based model of in-flight instructions.
module tb_pipe_hazard_ctrl;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int KILL     = 1;

    logic       clk;
    logic       arst_n;
    logic       en;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       redirect;

    logic        stall_n, fif_n, fie_n;
    logic [1:0]  f1_n, f2_n;
    logic [31:0] cnt_n;
    logic        stall_f, fif_f, fie_f;
    logic [1:0]  f1_f, f2_f;
    logic [31:0] cnt_f;

    pipe_hazard_ctrl #(
        .REG_ADDR_W (5),
        .DEPTH      (DEPTH),
        .FWD_EN     (1'b1),
        .LOAD_LAT   (LOAD_LAT),
        .KILL_SLOTS (KILL),
        .CNT_W      (32)
    ) u_dut_fwd (
        .clk          (clk),
        .arst_n       (arst_n),
        .en           (en),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .redirect     (redirect),
        .stall        (stall_f),
        .flush_if_id  (fif_f),
        .flush_id_ex  (fie_f),
        .fwd_sel_rs1  (f1_f),
        .fwd_sel_rs2  (f2_f),
        .stall_cnt    (cnt_f)
    );

    pipe_hazard_ctrl #(
        .REG_ADDR_W (5),
        .DEPTH      (DEPTH),
        .FWD_EN     (1'b0),
        .LOAD_LAT   (LOAD_LAT),
        .KILL_SLOTS (KILL),
        .CNT_W      (32)
    ) u_dut_nof (
        .clk          (clk),
        .arst_n       (arst_n),
        .en           (en),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .redirect     (redirect),
        .stall        (stall_n),
        .flush_if_id  (fif_n),
        .flush_id_ex  (fie_n),
        .fwd_sel_rs1  (f1_n),
        .fwd_sel_rs2  (f2_n),
        .stall_cnt    (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       redir;
        logic       en;
    } in_t;

    typedef struct {
        in_t  x;
        logic e_st;
        int   e_f1;
        int   e_f2;
        int   e_cnt;
    } vec_t;

    // Model: each issued instruction and the cycle it entered EX.
    // Its stage index is the number of enabled cycles since then.
    // Model index: 0 = no forwarding, 1 = forwarding.
    typedef struct {
        int         m;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       killed;
        int         enter;
    } rec_t;

    rec_t        recs[$];
    vec_t        tbl[$];
    int          cyc;
    int          m_f1[2];
    int          m_f2[2];
    logic [31:0] m_cnt[2];
    int          n_cmp;
    int          n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int v, input int rs1, input int rs2, input int rd,
                               input int we, input int ld, input int redir, input int e);
        in_t x;
        x.v     = v[0];
        x.rs1   = 5'(rs1);
        x.rs2   = 5'(rs2);
        x.u1    = 1'b1;
        x.u2    = 1'b1;
        x.rd    = 5'(rd);
        x.we    = we[0];
        x.ld    = ld[0];
        x.redir = redir[0];
        x.en    = e[0];
        return x;
    endfunction

    task automatic add_vec(input in_t x, input int st, input int f1, input int f2, input int c);
        vec_t t;
        t.x     = x;
        t.e_st  = st[0];
        t.e_f1  = f1;
        t.e_f2  = f2;
        t.e_cnt = c;
        tbl.push_back(t);
    endtask

    // Youngest live producer of register s for model m.
    function automatic void find(input int m, input logic [4:0] s, input logic u,
                                 output logic hit, output int pos, output logic ld);
        hit = 1'b0;
        pos = 0;
        ld  = 1'b0;
        foreach (recs[i]) begin
            int p;
            p = cyc - recs[i].enter;
            if (recs[i].m == m && u && s != 0 && p >= 0 && p < DEPTH && !recs[i].killed &&
                recs[i].we && recs[i].rd == s && (!hit || p < pos)) begin
                hit = 1'b1;
                pos = p;
                ld  = recs[i].ld;
            end
        end
    endfunction

    function automatic void eval(input int m, input in_t x, output logic st, output logic ent,
                                 output int nf1, output int nf2);
        logic h1, h2, l1, l2, haz;
        int   p1, p2;
        find(m, x.rs1, x.u1, h1, p1, l1);
        find(m, x.rs2, x.u2, h2, p2, l2);
        if (m == 1) begin
            haz = (h1 && l1 && p1 < LOAD_LAT) || (h2 && l2 && p2 < LOAD_LAT);
        end else begin
            haz = h1 || h2;
        end
        st  = x.v && haz && !x.redir;
        ent = x.v && !st && !x.redir;
        nf1 = (ent && m == 1 && h1) ? p1 + 1 : 0;
        nf2 = (ent && m == 1 && h2) ? p2 + 1 : 0;
    endfunction

    task automatic do_cycle(input in_t x, output logic s_nof, output logic s_fwd);
        logic est[2];
        logic ent[2];
        int   nf1[2];
        int   nf2[2];
        id_valid     = x.v;
        id_rs1       = x.rs1;
        id_rs2       = x.rs2;
        id_uses_rs1  = x.u1;
        id_uses_rs2  = x.u2;
        id_rd        = x.rd;
        id_reg_write = x.we;
        id_is_load   = x.ld;
        redirect     = x.redir;
        en           = x.en;
        #2;
        for (int m = 0; m < 2; m++) eval(m, x, est[m], ent[m], nf1[m], nf2[m]);
        chk("stall_nofwd", stall_n, est[0]);
        chk("stall_fwd", stall_f, est[1]);
        chk("flush_if_id", fif_f, x.redir);
        chk("flush_id_ex", fie_f, x.redir);
        chk("flush_if_id_nofwd", fif_n, x.redir);
        chk("flush_id_ex_nofwd", fie_n, x.redir);
        s_nof = stall_n;
        s_fwd = stall_f;
        if (x.en) begin
            if (x.redir) begin
                foreach (recs[i]) begin
                    if (cyc - recs[i].enter < KILL) recs[i].killed = 1'b1;
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (ent[m]) begin
                    rec_t r;
                    r.m      = m;
                    r.rd     = x.rd;
                    r.we     = x.we;
                    r.ld     = x.ld;
                    r.killed = 1'b0;
                    r.enter  = cyc + 1;
                    recs.push_back(r);
                end
                m_f1[m] = nf1[m];
                m_f2[m] = nf2[m];
                if (est[m] && m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m] = m_cnt[m] + 1;
            end
            cyc++;
            for (int i = recs.size() - 1; i >= 0; i--) begin
                if (cyc - recs[i].enter >= DEPTH) recs.delete(i);
            end
        end
        @(posedge clk);
        #1;
        chk("fwd_rs1_nofwd", 32'(f1_n), m_f1[0]);
        chk("fwd_rs2_nofwd", 32'(f2_n), m_f2[0]);
        chk("cnt_nofwd", cnt_n, m_cnt[0]);
        chk("fwd_rs1_fwd", 32'(f1_f), m_f1[1]);
        chk("fwd_rs2_fwd", 32'(f2_f), m_f2[1]);
        chk("cnt_fwd", cnt_f, m_cnt[1]);
    endtask

    // Entered and left one cycle after a rising edge.
    task automatic reset_dut();
        id_valid     = 1'b1;
        id_rs1       = 5'd7;
        id_rs2       = 5'd7;
        id_uses_rs1  = 1'b1;
        id_uses_rs2  = 1'b1;
        id_rd        = 5'd0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
        redirect     = 1'b0;
        en           = 1'b1;
        arst_n       = 1'b0;
        #2;
        recs.delete();
        for (int m = 0; m < 2; m++) begin
            m_f1[m]  = 0;
            m_f2[m]  = 0;
            m_cnt[m] = '0;
        end
        chk("rst_stall_fwd", stall_f, 0);
        chk("rst_stall_nofwd", stall_n, 0);
        chk("rst_flush_if_id", fif_f, 0);
        chk("rst_flush_id_ex", fie_f, 0);
        chk("rst_fwd_rs1", 32'(f1_f), 0);
        chk("rst_fwd_rs2", 32'(f2_f), 0);
        chk("rst_cnt_fwd", cnt_f, 0);
        chk("rst_cnt_nofwd", cnt_n, 0);
        chk("rst_fwd_rs1_nofwd", 32'(f1_n), 0);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic s0, s1;
        in_t  nop;
        in_t  x;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        nop   = mk(0, 0, 0, 0, 0, 0, 0, 1);

        // Directed vectors, expectations for the forwarding controller:
        // {inputs}, stall, fwd_sel_rs1, fwd_sel_rs2 and stall_cnt after the edge.
        add_vec(mk(1, 1, 2, 5, 1, 0, 0, 1), 0, 0, 0, 0);  // add x5,x1,x2
        add_vec(mk(1, 5, 1, 6, 1, 0, 0, 1), 0, 1, 0, 0);  // sub x6,x5,x1
        for (int i = 0; i < 3; i++) add_vec(nop, 0, 0, 0, 0);
        add_vec(mk(1, 2, 0, 7, 1, 1, 0, 1), 0, 0, 0, 0);  // ld x7
        add_vec(mk(1, 7, 7, 8, 1, 0, 0, 1), 1, 0, 0, 1);  // add x8,x7,x7: load-use
        add_vec(mk(1, 7, 7, 8, 1, 0, 0, 1), 0, 2, 2, 1);
        for (int i = 0; i < 3; i++) add_vec(nop, 0, 0, 0, 1);
        for (int d = 2; d <= 4; d++) begin
            add_vec(mk(1, 0, 0, 3, 1, 0, 0, 1), 0, 0, 0, 1);  // producer of x3
            for (int i = 0; i < d - 1; i++) add_vec(nop, 0, 0, 0, 1);
            add_vec(mk(1, 3, 0, 0, 0, 0, 0, 1), 0, (d == 2) ? 2 : (d == 3) ? 3 : 0, 0, 1);
            for (int i = 0; i < 3; i++) add_vec(nop, 0, 0, 0, 1);
        end
        add_vec(mk(1, 0, 0, 0, 1, 0, 0, 1), 0, 0, 0, 1);  // writes x0
        add_vec(mk(1, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1);  // reads x0
        for (int i = 0; i < 3; i++) add_vec(nop, 0, 0, 0, 1);
        add_vec(mk(1, 0, 0, 4, 1, 1, 0, 1), 0, 0, 0, 1);  // ld x4
        add_vec(mk(1, 4, 0, 0, 0, 0, 1, 1), 0, 0, 0, 1);  // x4 consumer during redirect
        add_vec(mk(1, 4, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1);  // ld x4 was killed

        arst_n = 1'b0;
        id_valid = 1'b0;
        redirect = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;
        reset_dut();

        foreach (tbl[i]) begin
            do_cycle(tbl[i].x, s0, s1);
            chk($sformatf("tbl%0d_stall", i), s1, tbl[i].e_st);
            chk($sformatf("tbl%0d_fwd_rs1", i), 32'(f1_f), tbl[i].e_f1);
            chk($sformatf("tbl%0d_fwd_rs2", i), 32'(f2_f), tbl[i].e_f2);
            chk($sformatf("tbl%0d_cnt", i), cnt_f, tbl[i].e_cnt);
        end

        // No forwarding, distance-1 dependency on x9: DEPTH stall cycles.
        reset_dut();
        do_cycle(mk(1, 0, 0, 9, 1, 0, 0, 1), s0, s1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(mk(1, 9, 0, 0, 0, 0, 0, 1), s0, s1);
            chk($sformatf("nofwd_x9_stall%0d", i), s0, (i < 3) ? 1 : 0);
        end
        chk("nofwd_x9_cnt", cnt_n, 3);
        chk("nofwd_x9_fwd", 32'(f1_n), 0);
        do_cycle(mk(1, 0, 0, 0, 1, 0, 0, 1), s0, s1);
        do_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1), s0, s1);
        chk("nofwd_x0_stall", s0, 0);

        // Freeze with en=0 while a load-use stall is pending.
        reset_dut();
        do_cycle(mk(1, 0, 0, 5, 1, 0, 0, 1), s0, s1);
        do_cycle(nop, s0, s1);
        do_cycle(mk(1, 5, 0, 7, 1, 1, 0, 1), s0, s1);
        chk("frz_pre_fwd", 32'(f1_f), 2);
        for (int i = 0; i < 5; i++) begin
            do_cycle(mk(1, 7, 7, 8, 1, 0, 0, 0), s0, s1);
            chk($sformatf("frz%0d_stall", i), s1, 1);
            chk($sformatf("frz%0d_fwd", i), 32'(f1_f), 2);
            chk($sformatf("frz%0d_cnt", i), cnt_f, 0);
        end
        do_cycle(mk(1, 7, 7, 8, 1, 0, 0, 1), s0, s1);
        chk("frz_run_stall", s1, 1);
        chk("frz_run_cnt", cnt_f, 1);
        do_cycle(mk(1, 7, 7, 8, 1, 0, 0, 1), s0, s1);
        chk("frz_go_stall", s1, 0);
        chk("frz_go_fwd1", 32'(f1_f), 2);
        chk("frz_go_fwd2", 32'(f2_f), 2);

        // Reset with a load in flight clears tracking.
        do_cycle(mk(1, 0, 0, 7, 1, 1, 0, 1), s0, s1);
        reset_dut();
        do_cycle(mk(1, 7, 7, 8, 1, 0, 0, 1), s0, s1);
        chk("arst_stall_fwd", s1, 0);
        chk("arst_stall_nofwd", s0, 0);
        chk("arst_cnt", cnt_f, 0);
        chk("arst_fwd", 32'(f1_f), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_dut();
            x.v     = ($urandom_range(0, 9) < 8);
            x.rs1   = 5'($urandom_range(0, 7));
            x.rs2   = 5'($urandom_range(0, 7));
            x.u1    = ($urandom_range(0, 3) != 0);
            x.u2    = ($urandom_range(0, 3) != 0);
            x.rd    = 5'($urandom_range(0, 7));
            x.we    = ($urandom_range(0, 3) != 0);
            x.ld    = ($urandom_range(0, 2) == 0);
            x.redir = ($urandom_range(0, 9) == 0);
            x.en    = ($urandom_range(0, 9) != 0);
            do_cycle(x, s0, s1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
